// File: rtl/sync_chain.sv
//------------------------------------------------------------------------------
// Module   : sync_chain
// Brief    : Plain shift of synchronous-reset flops for bringing a single-bit
//            asynchronous signal into the clk domain.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d_i};
        end
    end

    assign q_o = r_sync[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/debounce_sync.sv
//------------------------------------------------------------------------------
// Module   : debounce_sync
// Brief    : Synchronizes and debounces a bouncy input, producing a clean level
//            with single-cycle rise/fall strobes.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module debounce_sync #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic busy_o
);

    localparam int CNT_W = ($clog2(DEBOUNCE_CYCLES) > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             w_sync_q;
    logic             w_mismatch;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_rise;
    logic             r_fall;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync_chain (
        .clk   (clk),
        .reset (reset),
        .d_i   (raw_i),
        .q_o   (w_sync_q)
    );

    assign w_mismatch = (w_sync_q != r_level);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (!w_mismatch) begin
                r_cnt <= '0;
            end else if (r_cnt == C_CNT_MAX) begin
                // Candidate held long enough: commit it and strobe the direction.
                r_cnt   <= '0;
                r_level <= w_sync_q;
                r_rise  <= w_sync_q;
                r_fall  <= ~w_sync_q;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign level_o = r_level;
    assign rise_o  = r_rise;
    assign fall_o  = r_fall;
    assign busy_o  = (r_cnt != '0);

endmodule

`default_nettype wire

// File: tb/tb_debounce_sync.sv
//------------------------------------------------------------------------------
// Module   : tb_debounce_sync
// Brief    : Scoreboard bench for debounce_sync, two builds (DEBOUNCE 4 and 1).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_debounce_sync;

    localparam int S = 2;
    localparam int N = 4096;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic raw_i = 1'b1;

    logic level_a, rise_a, fall_a, busy_a;
    logic level_b, rise_b, fall_b, busy_b;

    always #5 clk = ~clk;

    debounce_sync #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(4)) dut_a (
        .clk(clk), .reset(reset), .raw_i(raw_i),
        .level_o(level_a), .rise_o(rise_a), .fall_o(fall_a), .busy_o(busy_a)
    );

    debounce_sync #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(1)) dut_b (
        .clk(clk), .reset(reset), .raw_i(raw_i),
        .level_o(level_b), .rise_o(rise_b), .fall_o(fall_b), .busy_o(busy_b)
    );

    // Reference model: a level flips once the synchronized input has disagreed
    // with it on each of the last D edges since the most recent flip or reset.
    int         dc [2] = '{4, 1};
    logic       raw_samp [0:N-1];
    logic       sync_after [0:N-1];
    logic       lvl [2];
    int         ev [2];
    int         n = 0;
    int         lr = 0;
    bit         started = 0;
    logic [7:0] exp_q [$];

    always @(posedge clk) begin
        logic [7:0] e;
        logic       flip;
        int         m;
        n++;
        e = '0;
        if (n >= N) begin
            $display("FAIL model_overflow cycle=%0d exceeds required bound %0d", n, N);
            $fatal(1);
        end
        raw_samp[n] = raw_i;
        if (reset) begin
            lr = n;
            sync_after[n] = 1'b0;
            for (int i = 0; i < 2; i++) begin
                lvl[i] = 1'b0;
                ev[i]  = n;
            end
        end else begin
            m = n - S + 1;
            sync_after[n] = (m > lr) ? raw_samp[m] : 1'b0;
            for (int i = 0; i < 2; i++) begin
                logic rs, fl, bz;
                flip = (n - dc[i] >= ev[i]);
                for (int j = n - dc[i]; j < n; j++)
                    if (flip && sync_after[j] == lvl[i]) flip = 1'b0;
                rs = flip && !lvl[i];
                fl = flip && lvl[i];
                bz = !flip && (n - 1 >= ev[i]) && (sync_after[n-1] != lvl[i]);
                if (flip) begin
                    lvl[i] = ~lvl[i];
                    ev[i]  = n;
                end
                e[i*4 +: 4] = {lvl[i], rs, fl, bz};
            end
        end
        exp_q.push_back(e);
        started = 1;
    end

    int n_checks = 0;
    int n_pass   = 0;

    always @(negedge clk) begin
        logic [7:0] e;
        logic [3:0] got_a, got_b;
        if (started) begin
            got_a = {level_a, rise_a, fall_a, busy_a};
            got_b = {level_b, rise_b, fall_b, busy_b};
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL scoreboard_empty cycle=%0d got no expected entry, required one", n);
            end else begin
                e = exp_q.pop_front();
                n_checks++;
                if (got_a === e[3:0]) n_pass++;
                else $display("FAIL deb4_outputs cycle=%0d {level,rise,fall,busy} got=%b required=%b",
                              n, got_a, e[3:0]);
                n_checks++;
                if (got_b === e[7:4]) n_pass++;
                else $display("FAIL deb1_outputs cycle=%0d {level,rise,fall,busy} got=%b required=%b",
                              n, got_b, e[7:4]);
            end
        end
    end

    task automatic hold(input logic v, input int cycles, input logic r = 1'b0);
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            raw_i = v;
            reset = r;
        end
    endtask

    initial begin
        // Reset with raw high, then the level must rise after release.
        hold(1'b1, 3, 1'b1);
        hold(1'b1, 10);
        hold(1'b0, 10);
        hold(1'b1, 10);
        hold(1'b0, 10);
        // Bounce: alternating samples never hold long enough.
        for (int k = 0; k < 4; k++) begin
            hold(1'b1, 1);
            hold(1'b0, 1);
        end
        hold(1'b0, 8);
        // Glitch one cycle short of the threshold, then one exactly at it.
        hold(1'b1, 3);
        hold(1'b0, 8);
        hold(1'b1, 4);
        hold(1'b0, 12);
        // Reset in the middle of a qualification.
        hold(1'b1, 4);
        hold(1'b1, 1, 1'b1);
        hold(1'b1, 10);
        hold(1'b0, 10);
        // Single-cycle pulses.
        hold(1'b1, 1);
        hold(1'b0, 6);
        hold(1'b1, 1);
        hold(1'b0, 6);
        // Randomized runs with occasional resets.
        for (int k = 0; k < 300; k++) begin
            logic v;
            v = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0)
                hold(v, $urandom_range(1, 3), 1'b1);
            else
                hold(v, $urandom_range(1, 8));
        end
        hold(1'b0, 10);
        @(negedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/debounce_sync.md
Name: debounce_sync

Overview:
Input-conditioning stage that sits directly upstream of the team's flop/register stage and drives its data input. It takes an asynchronous, bouncy single-bit input and passes it through a multi-flop synchronizer. A stability counter then debounces it. The block produces a clean level plus single-cycle rise/fall strobes, all in the clk domain.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops (>= 2).
DEBOUNCE_CYCLES, 16, consecutive cycles the synchronized input must differ from level_o before level_o toggles (>= 1).
CNT_W, $clog2(DEBOUNCE_CYCLES)>1 ? $clog2(DEBOUNCE_CYCLES) : 1, counter width (localparam, derived; not overridable).

Ports:
clk  input  1  single clock; all state updates on posedge.
reset  input  1  synchronous, active-high reset.
raw_i  input  1  asynchronous raw input (button/pin); may bounce or glitch.
level_o  output  1  debounced, synchronized level; registered.
rise_o  output  1  one-cycle pulse coincident with level_o 0->1.
fall_o  output  1  one-cycle pulse coincident with level_o 1->0.
busy_o  output  1  high while a candidate change is being qualified (counter nonzero).

Behaviour:
- Reset (sampled on posedge clk while reset=1): all sync flops, level_o, counter, rise_o and fall_o go to 0. busy_o is 0. The reset value of level_o is 0 regardless of raw_i.
- Synchronizer: raw_i shifts through SYNC_STAGES flops. sync_q is the last stage. No logic between stages.
- Mismatch: mismatch = (sync_q != level_o).
- Counter, evaluated each cycle with reset=0:
  - mismatch=0: counter <= 0.
  - mismatch=1 and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - mismatch=1 and counter == DEBOUNCE_CYCLES-1: level_o <= sync_q, counter <= 0. rise_o or fall_o is asserted for exactly that next cycle, according to direction.
- Strobes: rise_o and fall_o are registered and default to 0 every cycle they are not set. They are never both high. Each is high for exactly one cycle per level_o transition.
- busy_o = (counter != 0), combinational from the counter register.
- Latency: for a clean step on raw_i, number clock edges from 1, where edge 1 is the first edge that samples the new value. level_o and the strobe change at edge SYNC_STAGES+DEBOUNCE_CYCLES.
- Glitch rejection: if sync_q returns to level_o before the counter completes, the counter clears and no strobe fires. Qualification restarts from 0 on the next mismatch.
- DEBOUNCE_CYCLES=1: level_o follows sync_q with one extra cycle of delay; every change strobes.
- No wrap-around: the counter never exceeds DEBOUNCE_CYCLES-1.
- Reset mid-operation: any in-progress count is discarded and no strobe fires in the cycle after reset. If raw_i is held high through reset, rise_o fires SYNC_STAGES+DEBOUNCE_CYCLES edges after reset deasserts. This is intended.
- reset has priority over all other updates.

Decomposition:
- No shared package types needed. The CNT_W derivation stays a local parameter.
- One sub-module: sync_chain (parameter STAGES; ports clk, reset, d_i, q_o). It is a plain shift of synchronous-reset flops and is reusable by later stages. The debounce counter, level register and strobe logic stay in debounce_sync.

Test Plan:
1. Reset check (SYNC_STAGES=2, DEBOUNCE_CYCLES=4): raw_i=1 held through 3 reset cycles -> level_o=0, rise_o=0, fall_o=0, busy_o=0 during reset; after release, rise_o pulses once at edge 6 and level_o=1 from then on.
2. Clean rising step: raw_i 0->1 sampled at edge 1 -> busy_o high for edges 3-5; level_o=1 and rise_o=1 after edge 6; rise_o=0 after edge 7.
3. Bounce rejection: raw_i toggles 1,0,1,0 on alternate cycles, then stays 0 -> level_o stays 0, no strobes, counter clears each time sync_q returns to 0.
4. Short glitch at threshold: raw_i high for exactly DEBOUNCE_CYCLES-1 (=3) cycles, then low -> no rise_o, and busy_o returns to 0.
5. Falling step after stable high: level_o=1, then raw_i 1->0 -> fall_o pulses exactly once at edge 6 after sampling; rise_o stays 0.
6. Reset mid-count: assert reset when counter=2 -> counter=0, level_o=0, no strobe the cycle after reset; the count restarts from 0 after release.
7. DEBOUNCE_CYCLES=1 build: single-cycle raw_i pulse (one sampled edge) -> level_o mirrors it with 3-edge latency, then rise_o and fall_o each pulse once on consecutive cycles.
